// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe -- parameterised register pipeline with per-stage valid flags.
//
// Data and valid travel together through DEPTH register stages. A registered
// FILL counter tracks how many stages currently hold valid data. The active
// clock edge is selected at elaboration time with NEG_EDGE.
//
// Parameters
//   WIDTH    data width in bits (1..64)
//   DEPTH    number of register stages (1..16)
//   NEG_EDGE 0 = act on rising CLK edge, 1 = act on falling CLK edge
//   INIT     data value loaded by RESET and CLEAR
//
// Ports
//   CLK    in   clock
//   RESET  in   asynchronous active-high reset
//   CE     in   clock enable, stages advance only when high
//   CLEAR  in   synchronous clear of every stage (overrides CE)
//   D      in   data into stage 0
//   DV     in   valid flag accompanying D
//   Q      out  data of the last stage
//   QV     out  valid flag of the last stage
//   FILL   out  number of stages holding valid data
// -----------------------------------------------------------------------------
module dff_pipe #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      DEPTH    = 4,
    parameter bit               NEG_EDGE = 1'b0,
    parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}},
    localparam int unsigned     FW       = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             CLEAR,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic [FW-1:0]    FILL
);

    localparam logic [DEPTH-1:0][WIDTH-1:0] INIT_ALL = {DEPTH{INIT}};

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            vld_q,  vld_d;
    logic [FW-1:0]               fill_q, fill_d;

    // Next-state: CLEAR wins over CE; with neither, everything holds.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        fill_d = fill_q;
        if (CLEAR) begin
            data_d = INIT_ALL;
            vld_d  = '0;
            fill_d = '0;
        end else if (CE) begin
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                data_d[k] = data_q[k-1];
                vld_d[k]  = vld_q[k-1];
            end
            data_d[0] = D;
            vld_d[0]  = DV;
            // One valid may enter and one may leave per advance. When the
            // pipe is full the last stage is valid, so the count cannot
            // exceed DEPTH; when the last stage is valid the count is at
            // least 1, so it cannot underflow.
            fill_d = fill_q + FW'(DV) - FW'(vld_q[DEPTH-1]);
        end
    end

    // State registers on the selected edge; only one branch is elaborated.
    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge CLK or posedge RESET) begin
            if (RESET) begin
                data_q <= INIT_ALL;
                vld_q  <= '0;
                fill_q <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
                fill_q <= fill_d;
            end
        end
    end else begin : g_pos
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                data_q <= INIT_ALL;
                vld_q  <= '0;
                fill_q <= '0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
                fill_q <= fill_d;
            end
        end
    end

    // Outputs come straight from the last stage registers.
    assign Q    = data_q[DEPTH-1];
    assign QV   = vld_q[DEPTH-1];
    assign FILL = fill_q;

endmodule

// File: tb/tb_dff_pipe.sv
// -----------------------------------------------------------------------------
// tb_dff_pipe -- self-checking bench for dff_pipe.
//
// u_a: WIDTH=8, DEPTH=4, rising edge, INIT=0xA5. Reference model is a queue
//      of {valid,data} entries; FILL is the count of valid entries.
// u_b: WIDTH=8, DEPTH=1, falling edge, INIT=0. Reference model is one entry.
// -----------------------------------------------------------------------------
module tb_dff_pipe;

    localparam int         W      = 8;
    localparam int         DA     = 4;
    localparam int         DB     = 1;
    localparam logic [7:0] INIT_A = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, ce_a, clr_a, dv_a, qv_a;
    logic [7:0] d_a, q_a;
    logic [2:0] fill_a;

    logic       rst_b, ce_b, clr_b, dv_b, qv_b;
    logic [7:0] d_b, q_b;
    logic [0:0] fill_b;

    dff_pipe #(.WIDTH(W), .DEPTH(DA), .NEG_EDGE(1'b0), .INIT(INIT_A)) u_a (
        .CLK(clk), .RESET(rst_a), .CE(ce_a), .CLEAR(clr_a), .D(d_a), .DV(dv_a),
        .Q(q_a), .QV(qv_a), .FILL(fill_a)
    );

    dff_pipe #(.WIDTH(W), .DEPTH(DB), .NEG_EDGE(1'b1), .INIT(8'h00)) u_b (
        .CLK(clk), .RESET(rst_b), .CE(ce_b), .CLEAR(clr_b), .D(d_b), .DV(dv_b),
        .Q(q_b), .QV(qv_b), .FILL(fill_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model for u_a ----------------
    logic [8:0] mq[$];

    task automatic model_a_reset();
        mq.delete();
        repeat (DA) mq.push_back({1'b0, INIT_A});
    endtask

    task automatic model_a_edge();
        if (clr_a) model_a_reset();
        else if (ce_a) begin
            mq.push_front({dv_a, d_a});
            void'(mq.pop_back());
        end
    endtask

    function automatic int model_fill();
        int n = 0;
        foreach (mq[i]) n += int'(mq[i][8]);
        return n;
    endfunction

    task automatic check_a(input string tag);
        logic [8:0] last;
        last = mq[DA-1];
        chk({tag, "/q"},    64'(q_a),    64'(last[7:0]));
        chk({tag, "/qv"},   64'(qv_a),   64'(last[8]));
        chk({tag, "/fill"}, 64'(fill_a), 64'(model_fill()));
    endtask

    task automatic step_a(input string tag);
        @(posedge clk);
        model_a_edge();
        #1;
        check_a(tag);
    endtask

    // ---------------- reference model for u_b ----------------
    logic [7:0] mb_d;
    logic       mb_v;

    task automatic check_b(input string tag);
        chk({tag, "/q"},    64'(q_b),    64'(mb_d));
        chk({tag, "/qv"},   64'(qv_b),   64'(mb_v));
        chk({tag, "/fill"}, 64'(fill_b), 64'(mb_v));
    endtask

    initial begin
        rst_a = 1'b1; ce_a = 1'b0; clr_a = 1'b0; dv_a = 1'b0; d_a = 8'h00;
        rst_b = 1'b1; ce_b = 1'b0; clr_b = 1'b0; dv_b = 1'b0; d_b = 8'h00;
        mb_d = 8'h00; mb_v = 1'b0;

        // Reset is asynchronous: outputs settle before any clock edge.
        #1;
        chk("rst/q",    64'(q_a),    64'(INIT_A));
        chk("rst/qv",   64'(qv_a),   64'd0);
        chk("rst/fill", 64'(fill_a), 64'd0);
        chk("rstb/q",   64'(q_b),    64'd0);
        chk("rstb/qv",  64'(qv_b),   64'd0);
        model_a_reset();

        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;

        // Stream 0x11..0x55: first word appears on edge 4.
        ce_a = 1'b1; dv_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_a = 8'(8'h11 * (i + 1));
            step_a("stream");
            chk("stream/fill_k", 64'(fill_a), 64'((i < 4) ? i + 1 : 4));
            if (i == 3) begin
                chk("stream/q_e4",  64'(q_a),  64'h11);
                chk("stream/qv_e4", 64'(qv_a), 64'd1);
            end
            if (i == 4) chk("stream/q_e5", 64'(q_a), 64'h22);
        end

        // CE low for three edges: everything frozen.
        ce_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_a = 8'($urandom); dv_a = 1'($urandom);
            step_a("hold");
            chk("hold/q_k",    64'(q_a),    64'h22);
            chk("hold/fill_k", 64'(fill_a), 64'd4);
        end

        // Resume in order.
        ce_a = 1'b1; dv_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_a = 8'(8'h66 + 8'h11 * i);
            step_a("resume");
            chk("resume/q_k", 64'(q_a), 64'(8'h33 + 8'h11 * i));
        end
        chk("full/fill", 64'(fill_a), 64'd4);

        // CLEAR with CE low still clears.
        ce_a = 1'b0; clr_a = 1'b1;
        step_a("clear");
        chk("clear/q",    64'(q_a),    64'(INIT_A));
        chk("clear/qv",   64'(qv_a),   64'd0);
        chk("clear/fill", 64'(fill_a), 64'd0);
        clr_a = 1'b0;

        // Fill, then async reset between edges.
        ce_a = 1'b1; dv_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_a = 8'($urandom);
            step_a("refill");
        end
        chk("refill/fill", 64'(fill_a), 64'd4);
        #3 rst_a = 1'b1;
        #1;
        chk("arst/q",    64'(q_a),    64'(INIT_A));
        chk("arst/qv",   64'(qv_a),   64'd0);
        chk("arst/fill", 64'(fill_a), 64'd0);
        model_a_reset();
        #1 rst_a = 1'b0;
        dv_a = 1'b1; d_a = 8'h5A;
        step_a("post_rst");
        chk("post_rst/fill", 64'(fill_a), 64'd1);

        // Alternating valid.
        clr_a = 1'b1;
        step_a("clr2");
        clr_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            dv_a = (i % 2 == 0);
            d_a  = 8'($urandom);
            step_a("alt");
            if (i >= 3) begin
                chk("alt/qv_pat",  64'(qv_a), 64'(((i - 3) % 2) == 0));
                chk("alt/fill_le2", 64'(fill_a <= 3'd2), 64'd1);
            end
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            d_a   = 8'($urandom);
            dv_a  = 1'($urandom);
            ce_a  = ($urandom_range(0, 3) != 0);
            clr_a = ($urandom_range(0, 19) == 0);
            step_a("rand");
        end
        clr_a = 1'b0;

        // u_b: falling-edge, single stage.
        @(negedge clk); #1;
        d_b = 8'h3C; dv_b = 1'b1; ce_b = 1'b1;
        @(posedge clk); #1;
        chk("neg/rise_q",  64'(q_b),  64'd0);
        chk("neg/rise_qv", 64'(qv_b), 64'd0);
        @(negedge clk); #1;
        chk("neg/fall_q",  64'(q_b),  64'h3C);
        chk("neg/fall_qv", 64'(qv_b), 64'd1);
        mb_d = 8'h3C; mb_v = 1'b1;

        for (int i = 0; i < 40; i++) begin
            d_b   = 8'($urandom);
            dv_b  = 1'($urandom);
            ce_b  = ($urandom_range(0, 3) != 0);
            clr_b = ($urandom_range(0, 9) == 0);
            @(posedge clk); #1;
            check_b("negr_rise");
            @(negedge clk);
            if (clr_b) begin
                mb_d = 8'h00; mb_v = 1'b0;
            end else if (ce_b) begin
                mb_d = d_b; mb_v = dv_b;
            end
            #1;
            check_b("negr_fall");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 4, number of register stages (1..16).
REQ-003 Parameter NEG_EDGE, default 1'b0, active clock edge: 0 = rising, 1 = falling.
REQ-004 Parameter INIT, default {WIDTH{1'b0}}, data value loaded by reset and clear.
REQ-005 Port CLK  input  1  single clock; all state changes on the edge selected by NEG_EDGE.
REQ-006 Port RESET  input  1  asynchronous, active-high reset.
REQ-007 Port CE  input  1  clock enable; stages advance only when high.
REQ-008 Port CLEAR  input  1  synchronous clear of all stages.
REQ-009 Port D  input  WIDTH  data into stage 0.
REQ-010 Port DV  input  1  valid flag accompanying D.
REQ-011 Port Q  output  WIDTH  data of last stage (DEPTH-1).
REQ-012 Port QV  output  1  valid flag of last stage.
REQ-013 Port FILL  output  $clog2(DEPTH+1)  count of stages holding valid data.

Function
REQ-014 Each stage k (0..DEPTH-1) SHALL hold a WIDTH-bit data register and a 1-bit valid register.
REQ-015 The module SHALL act only on the active edge: rising edge when NEG_EDGE=0, falling edge when NEG_EDGE=1; the other edge SHALL have no effect.
REQ-016 On an active edge with CE=1 and CLEAR=0: stage 0 SHALL load {D, DV}, and each stage k>0 SHALL load stage k-1.
REQ-017 On an active edge with CE=0 and CLEAR=0: all stages and FILL SHALL hold.
REQ-018 On an active edge with CLEAR=1: all data registers SHALL load INIT, all valid bits SHALL load 0, and FILL SHALL load 0, regardless of CE.
REQ-019 Latency: a {D, DV} sampled on an edge SHALL appear on {Q, QV} after exactly DEPTH active edges with CE=1; with DEPTH=1 it appears after the sampling edge itself.
REQ-020 Q and QV SHALL be driven directly from the last stage registers, with no combinational path from D, DV, CE or CLEAR.
REQ-021 FILL SHALL be a registered count, updated on each advancing edge: FILL_next = FILL + DV - QV_before_edge, with QV_before_edge being the last-stage valid bit before the edge.
REQ-022 FILL SHALL always equal the population count of the valid bits, stay within 0..DEPTH, and never wrap.
REQ-023 Data registers SHALL shift independently of valid; stages with valid=0 still carry D.
REQ-024 Priority SHALL be RESET > CLEAR > CE.

Reset
REQ-025 While RESET=1, all data registers SHALL equal INIT, all valid bits and FILL SHALL be 0, and Q=INIT, QV=0, immediately and without waiting for a clock edge.
REQ-026 RESET asserted mid-stream SHALL discard all in-flight data; the first active edge after RESET falls SHALL behave per REQ-016..018.
REQ-027 At simulation start, before any RESET, registers SHALL hold INIT, valid bits SHALL be 0, and FILL SHALL be 0.

Verification
REQ-028 WIDTH=8, DEPTH=4, NEG_EDGE=0, CE=1: drive D=0x11,0x22,0x33,0x44,0x55 with DV=1 on consecutive edges -> Q=0x11, QV=1 on edge 4, then 0x22 on edge 5; FILL reads 1,2,3,4,4.
REQ-029 Same setup, CE=0 for 3 edges mid-stream -> Q, QV and FILL stay frozen for those 3 edges, and the stream resumes in order when CE returns high.
REQ-030 DEPTH=4 full with FILL=4, assert CLEAR with CE=0 -> after the next edge Q=INIT, QV=0, FILL=0.
REQ-031 INIT=0xA5, assert RESET asynchronously between edges while the pipeline is full -> Q=0xA5, QV=0, FILL=0 before the next edge; release RESET and drive DV=1 -> FILL=1 after the next edge.
REQ-032 NEG_EDGE=1, DEPTH=1: D=0x3C, DV=1 presented before a falling edge -> Q=0x3C, QV=1 after that falling edge, with no change at the preceding rising edge.
REQ-033 DEPTH=4, alternating DV=1,0,1,0 with CE=1 -> QV pattern 1,0,1,0 starting at edge 4; FILL never exceeds 2 after edge 4.
